// File: rtl/codec_rx.sv
// Receive side of a left-justified serial audio codec link. Generates the
// codec clocks from one free-running counter and deserialises 16-bit L/R pairs.
module codec_rx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SDout,
    output logic        MCLK,
    output logic        SCLK,
    output logic        LRCLK,
    output logic        RSTn,
    output logic [15:0] lft_smpl,
    output logic [15:0] rght_smpl,
    output logic        wrt_smpl
);

    localparam int DATA_W = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SYNC = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    localparam logic [10:0] LFT_LAST  = 11'd991;
    localparam logic [10:0] RGHT_LAST = 11'd2015;
    localparam logic [10:0] FRM_LAST  = 11'd2047;

    logic [10:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] lft_q, lft_d;
    logic [DATA_W-1:0] rght_q, rght_d;
    logic              wrt_q, wrt_d;
    logic              rstn_q, rstn_d;
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        cnt_d   = cnt_q + 11'd1;
        shifted = {shreg_q[DATA_W-2:0], SDout};
        // SDout is sampled on the edge where SCLK rises, mid bit-cell.
        shreg_d = (cnt_q[5:0] == 6'd31) ? shifted : shreg_q;
        lft_d   = (cnt_q == LFT_LAST)  ? shifted : lft_q;
        rght_d  = (cnt_q == RGHT_LAST) ? shifted : rght_q;

        state_d = state_q;
        case (state_q)
            IDLE:    if (cnt_q == FRM_LAST) state_d = SYNC;
            SYNC:    if (cnt_q == FRM_LAST) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase

        // The SYNC frame fills the sample registers but is never announced.
        wrt_d  = (state_q == RUN) && (cnt_q == RGHT_LAST);
        rstn_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            lft_q   <= '0;
            rght_q  <= '0;
            wrt_q   <= 1'b0;
            rstn_q  <= 1'b0;
            state_q <= IDLE;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
            wrt_q   <= wrt_d;
            rstn_q  <= rstn_d;
            state_q <= state_d;
        end
    end

    assign MCLK      = cnt_q[1];
    assign SCLK      = cnt_q[5];
    assign LRCLK     = cnt_q[10];
    assign RSTn      = rstn_q;
    assign lft_smpl  = lft_q;
    assign rght_smpl = rght_q;
    assign wrt_smpl  = wrt_q;

endmodule

// File: tb/tb_codec_rx.sv
// Directed bench for codec_rx: a codec model feeds known L/R words and the
// bench checks reset, start-up latency, sample values and clock outputs.
module tb_codec_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SDout = 1'b0;
    logic        MCLK, SCLK, LRCLK, RSTn, wrt_smpl;
    logic [15:0] lft_smpl, rght_smpl;

    int n_cmp = 0;
    int n_mis = 0;

    logic [10:0] tcnt;
    int          fcnt;
    int          mode = 0;

    codec_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .SDout     (SDout),
        .MCLK      (MCLK),
        .SCLK      (SCLK),
        .LRCLK     (LRCLK),
        .RSTn      (RSTn),
        .lft_smpl  (lft_smpl),
        .rght_smpl (rght_smpl),
        .wrt_smpl  (wrt_smpl)
    );

    always #5 clk = ~clk;

    // Bench frame position, used only to drive the codec model.
    always @(posedge clk) begin
        if (!rst_n) begin
            tcnt <= '0;
            fcnt <= 0;
        end else begin
            tcnt <= tcnt + 11'd1;
            if (tcnt == 11'd2047) fcnt <= fcnt + 1;
        end
    end

    function automatic logic [15:0] word_l(input int m, input int f);
        if (m == 0) return 16'h0000;
        if (m == 1) return 16'hA5C3;
        return (f % 2 == 0) ? 16'h8000 : 16'h7FFF;
    endfunction

    function automatic logic [15:0] word_r(input int m, input int f);
        if (m == 0) return 16'h0000;
        if (m == 1) return 16'h1234;
        return (f % 2 == 0) ? 16'h0001 : 16'hFFFE;
    endfunction

    // Codec changes SDout on SCLK fall, MSB first, 16 bits per half.
    always @(negedge clk) begin
        logic [15:0] w;
        w = tcnt[10] ? word_r(mode, fcnt) : word_l(mode, fcnt);
        SDout = w[15 - int'(tcnt[9:6])];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pulse(output bit ok);
        int k;
        k = 0;
        do begin
            cyc();
            k++;
        end while (!wrt_smpl && k < 2200);
        ok = wrt_smpl;
        check("pulse_seen", {31'd0, wrt_smpl}, 32'd1);
    endtask

    task automatic check_zero_outputs(input string pfx);
        check({pfx, "_wrt"},   {31'd0, wrt_smpl}, 32'd0);
        check({pfx, "_rstn"},  {31'd0, RSTn}, 32'd0);
        check({pfx, "_lft"},   {16'd0, lft_smpl}, 32'd0);
        check({pfx, "_rght"},  {16'd0, rght_smpl}, 32'd0);
        check({pfx, "_clks"},  {29'd0, MCLK, SCLK, LRCLK}, 32'd0);
    endtask

    // Releases reset with cnt = 0 in cycle 1 and measures the first pulse.
    task automatic release_and_time(input string pfx, input bit chk_rstn, input logic [15:0] el, input logic [15:0] er);
        int cyc_no;
        rst_n  = 1'b1;
        cyc_no = 1;
        while (!wrt_smpl && cyc_no < 7000) begin
            cyc();
            cyc_no++;
            if (chk_rstn && cyc_no == 2048) check({pfx, "_rstn_c2048"}, {31'd0, RSTn}, 32'd0);
            if (chk_rstn && cyc_no == 2049) check({pfx, "_rstn_c2049"}, {31'd0, RSTn}, 32'd1);
        end
        check({pfx, "_first_pulse_cycle"}, cyc_no, 32'd6113);
        check({pfx, "_first_lft"},  {16'd0, lft_smpl}, {16'd0, el});
        check({pfx, "_first_rght"}, {16'd0, rght_smpl}, {16'd0, er});
    endtask

    initial begin
        bit ok;
        int sr_l, sr_r, mr, lr_tog, lr_bad, pulses, wide, bad_gap, last_at, run;
        logic ps, pm, pl, pw;

        // Reset state
        mode  = 0;
        rst_n = 1'b0;
        repeat (3) cyc();
        check_zero_outputs("reset");
        release_and_time("rel", 1'b1, 16'h0000, 16'h0000);

        // Constant pair every frame
        cyc();
        mode = 1;
        for (int i = 0; i < 3; i++) begin
            wait_pulse(ok);
            check("a5c3_lft",  {16'd0, lft_smpl}, 32'h0000A5C3);
            check("1234_rght", {16'd0, rght_smpl}, 32'h00001234);
        end

        // Clock outputs over one full frame
        sr_l = 0; sr_r = 0; mr = 0; lr_tog = 0; lr_bad = 0;
        ps = SCLK; pm = MCLK; pl = LRCLK;
        for (int i = 0; i < 2048; i++) begin
            cyc();
            if (SCLK && !ps) begin
                if (LRCLK) sr_r++;
                else sr_l++;
            end
            if (MCLK && !pm) mr++;
            if (LRCLK != pl) begin
                lr_tog++;
                if (!((tcnt == 11'd0 && !LRCLK) || (tcnt == 11'd1024 && LRCLK))) lr_bad++;
            end
            ps = SCLK; pm = MCLK; pl = LRCLK;
        end
        check("sclk_rises_left",  sr_l, 32'd16);
        check("sclk_rises_right", sr_r, 32'd16);
        check("mclk_periods",     mr, 32'd512);
        check("lrclk_toggles",    lr_tog, 32'd2);
        check("lrclk_toggle_pos", lr_bad, 32'd0);

        // Alternating extreme words
        wait_pulse(ok);
        cyc();
        mode = 2;
        for (int i = 0; i < 4; i++) begin
            wait_pulse(ok);
            check("alt_lft",  {16'd0, lft_smpl},  {16'd0, word_l(2, fcnt)});
            check("alt_rght", {16'd0, rght_smpl}, {16'd0, word_r(2, fcnt)});
            if (fcnt % 2 == 0) check("alt_even_lft", {16'd0, lft_smpl}, 32'h00008000);
            else               check("alt_odd_rght", {16'd0, rght_smpl}, 32'h0000FFFE);
        end

        // Pulse count, width and spacing over ten frames
        cyc();
        pulses = 0; wide = 0; bad_gap = 0; last_at = -1; run = 0; pw = 1'b0;
        for (int i = 0; i < 20480; i++) begin
            cyc();
            if (wrt_smpl) begin
                run++;
                if (run > 1) wide++;
                if (!pw) begin
                    if (last_at >= 0 && i - last_at != 2048) bad_gap++;
                    last_at = i;
                    pulses++;
                end
            end else begin
                run = 0;
            end
            pw = wrt_smpl;
        end
        check("ten_frame_pulses", pulses, 32'd10);
        check("pulse_width",      wide, 32'd0);
        check("pulse_spacing",    bad_gap, 32'd0);

        // Reset landing on the wrt_smpl cycle
        mode = 1;
        wait_pulse(ok);
        rst_n = 1'b0;
        cyc();
        check_zero_outputs("midrst");
        cyc();
        release_and_time("rerel", 1'b1, 16'hA5C3, 16'h1234);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/codec_rx.md
CODEC_RX -- requirements
Module: codec_rx

Interface
REQ-001 The module SHALL have a single clock `clk`: input, 1 bit, system clock, all logic rising-edge.
REQ-002 The module SHALL have `rst_n`: input, 1 bit, synchronous active-low reset, sampled on rising `clk`.
REQ-003 The module SHALL have `SDout`: input, 1 bit, serial data from the codec, left-justified, MSB first.
REQ-004 The module SHALL have `MCLK`: output, 1 bit, codec master clock, equal to `cnt[1]`.
REQ-005 The module SHALL have `SCLK`: output, 1 bit, serial bit clock, equal to `cnt[5]`.
REQ-006 The module SHALL have `LRCLK`: output, 1 bit, channel select, equal to `cnt[10]` (0 = left, 1 = right).
REQ-007 The module SHALL have `RSTn`: output, 1 bit, active-low codec reset, registered.
REQ-008 The module SHALL have `lft_smpl`: output, 16 bits, last complete left sample, registered.
REQ-009 The module SHALL have `rght_smpl`: output, 16 bits, last complete right sample, registered.
REQ-010 The module SHALL have `wrt_smpl`: output, 1 bit, one-`clk` pulse marking that a new left/right pair is valid.

Function
REQ-011 An 11-bit free-running counter `cnt` SHALL increment by 1 every `clk` and wrap from 2047 to 0.
- LRCLK period = 2048 clk.
- SCLK period = 64 clk.
- MCLK period = 4 clk.
REQ-012 A shift event SHALL occur on the clock edge ending any cycle where `cnt[5:0]` = 31.
- This is the same edge on which SCLK rises.
- Result: 16 events per LRCLK half.
REQ-013 On each shift event, the 16-bit shift register SHALL load `{shreg[14:0], SDout}`.
REQ-014 On the edge ending cycle `cnt` = 991 (16th left shift), `lft_smpl` SHALL load `{shreg[14:0], SDout}`.
REQ-015 On the edge ending cycle `cnt` = 2015 (16th right shift), `rght_smpl` SHALL load `{shreg[14:0], SDout}`.
REQ-016 The state machine SHALL have exactly three states: IDLE, SYNC, RUN.
REQ-017 IDLE: `RSTn` = 0.
- On the edge ending `cnt` = 2047, go to SYNC.
REQ-018 SYNC: `RSTn` = 1.
- Frame data is shifted and latched into `lft_smpl`/`rght_smpl`, but `wrt_smpl` stays 0.
- On the edge ending `cnt` = 2047, go to RUN.
REQ-019 RUN: `RSTn` = 1.
- `wrt_smpl` = 1 during exactly the cycle where `cnt` = 2016, and 0 at all other times.
- RUN holds until reset.
REQ-020 While `wrt_smpl` = 1, `lft_smpl` and `rght_smpl` SHALL both hold the current frame's pair.
- They stay stable until the next frame's latch edges (cnt 991 / 2015).
REQ-021 Sample width SHALL be exactly 16 bits; no sign extension or truncation.
- Bits beyond the 16th are never captured; each half has exactly 16 shift events.
REQ-022 `SDout` SHALL be sampled directly with no synchronizer, since it is synchronous to the locally generated SCLK.

Reset
REQ-023 When `rst_n` = 0 at a rising `clk`, the following SHALL all load 0 on that edge:
- `cnt`
- shift register
- `lft_smpl`, `rght_smpl`
- `wrt_smpl`
- `RSTn`
- state, which goes to IDLE.
REQ-024 Reset asserted mid-frame, including during RUN or on the `wrt_smpl` cycle, SHALL abort the frame immediately.
- No `wrt_smpl` pulse follows until a new IDLE→SYNC→RUN sequence completes.
REQ-025 After `rst_n` rises, the first `wrt_smpl` SHALL occur 2048 + 2048 + 2017 = 6113 clk later.
- Counted from the first non-reset edge, with `cnt` = 0 on that edge.
REQ-026 `MCLK`, `SCLK` and `LRCLK` SHALL be 0 during reset and follow `cnt` immediately afterwards.
- They are not gated by state.

Verification
REQ-027 Reset release, `SDout` held 0:
- `RSTn` = 0 for 2048 clk after release, then 1.
- `wrt_smpl` first pulses at clk 6113, with `lft_smpl` = `rght_smpl` = 0x0000.
REQ-028 Codec model drives left = 0xA5C3 and right = 0x1234 MSB-first, changing `SDout` on SCLK fall, every frame:
- every `wrt_smpl` in RUN presents `lft_smpl` = 0xA5C3 and `rght_smpl` = 0x1234.
REQ-029 Left = 0x8000 and right = 0x0001, alternating with 0x7FFF / 0xFFFE on the next frame:
- consecutive pulses show the exact values, with no bit slip and no channel swap.
REQ-030 Clock outputs over one frame:
- exactly 16 SCLK rising edges per LRCLK half.
- 512 MCLK periods per LRCLK period.
- LRCLK toggles at cnt 0 and 1024.
REQ-031 In RUN, count `wrt_smpl` pulses over 10 frames:
- exactly 10 pulses, each 1 clk wide, each 2048 clk apart.
REQ-032 `rst_n` = 0 for 1 clk at `cnt` = 2016 of a RUN frame:
- `wrt_smpl` = 0 after that edge.
- all outputs read 0.
- `RSTn` is low again, and the next pulse occurs 6113 clk after release.
